// File: rtl/multicycle_controller_pkg.sv
// Shared opcodes, datapath select encodings and FSM state type for the multicycle RV32I controller.
// The TRAP state exists only when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_LUI
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    S_TRAP
`endif
  } state_e;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the datapath (slave).
// Illegal is present only when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        InstrDone;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  modport master (
    input  Instr, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , output Illegal
`endif
  );

  modport slave (
    output Instr, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , input Illegal
`endif
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp, funct3, Instr[30] and the opcode R/I bit to the ALU operation.
module alu_decoder
  import riscv_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Instr[30] selects sub only for register-register ops; addi keeps add.
          3'b000:  alu_control = (funct7_5 && op_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath, with MemReady stalls.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap on unsupported opcodes.
module multicycle_controller
  import riscv_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  aluop_e     alu_op;
  logic [6:0] opcode;
  logic       pc_write, mem_write, ir_write, reg_write, instr_done;
  logic       adr_src;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_control;
  logic       unused_instr;

  assign opcode       = bus.Instr[6:0];
  assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    case (state_q)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALU;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTER: begin
        src_a   = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        src_a   = SRCA_ZERO;
        src_b   = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        src_a      = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        pc_write   = bus.Zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_JALR: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.Instr[14:12]),
    .funct7_5    (bus.Instr[30]),
    .op_5        (bus.Instr[5]),
    .alu_control (alu_control)
  );

  // Strobes are masked by rst_n directly so an in-flight store stops writing before the reset edge.
  assign bus.PCWrite    = pc_write & rst_n;
  assign bus.MemWrite   = mem_write & rst_n;
  assign bus.IRWrite    = ir_write & rst_n;
  assign bus.RegWrite   = reg_write & rst_n;
  assign bus.InstrDone  = instr_done & rst_n;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src_of(opcode);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign bus.Illegal    = (state_q == S_TRAP);
`endif

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32I datapath (shared ALU, single unified memory port, instruction and ALUOut registers), successor to the single-cycle `control_unit`. It decodes the latched instruction one state per cycle and drives the datapath's register enables, multiplexer selects and ALU operation. It also stalls on a memory-ready handshake. Supported set is unchanged: add, sub, and, or, slt, addi, andi, ori, lw, sw, beq, jal, jalr, lui.

## Interface
- Parameters: none; widths are fixed at RV32.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `Instr` in 32 — instruction register output; stable from the cycle after a FETCH handshake.
- `Zero` in 1 — ALU zero flag.
- `MemReady` in 1 — memory completes the current access this cycle.
- `PCWrite` out 1 — PC register enable.
- `AdrSrc` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite` out 1 — memory write strobe.
- `IRWrite` out 1 — instruction and OldPC register enable.
- `RegWrite` out 1 — register file write.
- `ResultSrc` out 2 — result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `ALUSrcA` out 2 — ALU A input: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- `ALUSrcB` out 2 — ALU B input: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ALUControl` out 3 — 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 3 — 000 I, 001 S, 010 B, 011 J, 100 U.
- `InstrDone` out 1 — one-cycle pulse in the last state of each instruction.
- `Illegal` out 1 — only present with the trap macro; see Configuration.

## Operation
- Moore FSM. Outputs depend on the state only, except for the `MemReady`/`Zero` qualified strobes listed below.
- `ImmSrc` is decoded combinationally from `Instr[6:0]` in every state:
  - lw, I-type and jalr: I.
  - sw: S. beq: B. jal: J. lui: U.
  - other opcodes: 000.
- ALU decoder, used in EXECUTER and EXECUTEI, by funct3:
  - 000: add. In EXECUTER with `Instr[30]` = 1: sub.
  - 010: slt. 110: or. 111: and.
  - any other funct3: add.
- Unlisted outputs are 0 in each state.

States, actions and transitions:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only when `MemReady`=1.
  - Holds while `MemReady`=0; moves to DECODE when it is 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011: MEMADR.
  - 0110011: EXECUTER. 0010011: EXECUTEI.
  - 1100011: BEQ. 1101111: JAL. 1100111: JALR. 0110111: LUI.
  - anything else: FETCH, or TRAP with the macro defined.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until `MemReady`=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00.
  - MemWrite=1 in every cycle of the state.
  - Holds until `MemReady`=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, decoded op, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, decoded op, then ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, add, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=`Zero`, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (rd gets OldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1, then JALR_LINK.
- JALR_LINK: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, then FETCH.
- `InstrDone` is asserted in:
  - MEMWB and ALUWB;
  - BEQ and JALR_LINK;
  - MEMWRITE when `MemReady`=1.

## Timing
- Latency with `MemReady` held at 1:
  - beq: 3 cycles.
  - R-type, I-type, sw, jal, jalr, lui: 4 cycles.
  - lw: 5 cycles.
- Each cycle with `MemReady`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `MemWrite` stays high through every MEMWRITE wait cycle; memory commits the write on the `MemReady` cycle.
- Reset:
  - While `rst_n`=0, PCWrite, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0 combinationally. This applies even mid-instruction, including during a MEMWRITE wait.
  - At the first rising edge with `rst_n`=0, the state becomes FETCH and `Illegal` becomes 0.
  - After reset, outputs take their FETCH values.
- The `Zero` input is sampled only in BEQ.

## Configuration
- `MULTICYCLE_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode in DECODE enters TRAP.
  - In TRAP, `Illegal`=1 and all strobes are 0.
  - TRAP is left only by reset.
- Macro undefined:
  - An unsupported opcode returns to FETCH, executing as a 2-cycle NOP with no strobes.
  - The `Illegal` port and the TRAP state are absent.

## Structure
- `riscv_pkg` holds:
  - the opcode constants;
  - the `ALUControl`, `ImmSrc`, `ResultSrc` and `ALUSrc` encodings;
  - the state enum.
- Sub-module `alu_decoder` maps ALUOp (00 add, 01 sub, 10 funct), funct3, `Instr[30]` and the opcode R/I bit to `ALUControl`.

## Test plan
- `Instr`=0x00000033 (add), `MemReady`=1 → states FETCH, DECODE, EXECUTER, ALUWB; `RegWrite`=1 and `InstrDone`=1 in cycle 4 only; `ALUControl`=000 in cycle 3.
- `Instr`=0x40000033 (sub) → `ALUControl`=001 in EXECUTER. `Instr`=0x00002033 (slt) → 101. `Instr`=0x00006013 (ori) → 011 with `ALUSrcB`=01.
- `Instr`=0x00002003 (lw), `MemReady` low for 2 cycles in MEMREAD → done in 7 cycles; `RegWrite` with `ResultSrc`=01 in the last cycle.
- `Instr`=0x00000063 (beq): with `Zero`=1, `PCWrite`=1 in cycle 3; with `Zero`=0, `PCWrite`=0; both complete in 3 cycles.
- `Instr`=0x00002023 (sw), `MemReady`=0 for 3 cycles, then `rst_n`=0 → `MemWrite` drops in the same cycle; state is FETCH after the edge.
- `Instr`=0x0000007F:
  - macro defined → `Illegal`=1 from cycle 3 and held until reset;
  - macro undefined → back in FETCH at cycle 3 with no strobes.
